// File: rtl/exmem_skid.sv
// EX/MEM writeback register built as a 2-entry skid buffer: the main entry drives
// the outputs, the skid entry absorbs the one beat that arrives as ready drops.
module exmem_skid #(
    parameter int AW             = 5,
    parameter int DW             = 32,
    parameter int CW             = 16,
    parameter int DROP_R0        = 1,
    parameter int ZERO_ON_BUBBLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_wr_address,
    input  logic [DW-1:0] in_wr_data,
    input  logic          in_wr_enable,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_wr_address,
    output logic [DW-1:0] out_wr_data,
    output logic          out_wr_enable,
    output logic [CW-1:0] stall_cycles
);

    // Handshake: a beat moves on a rising edge where valid and ready are both 1;
    // in_ready is a register, so it never depends on out_ready in the same cycle.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          in_ready_q;
    logic [AW-1:0] main_addr_q, skid_addr_q;
    logic [DW-1:0] main_data_q, skid_data_q;
    logic          main_en_q, skid_en_q;
    logic [CW-1:0] stall_q;

    logic accept, pop, in_en_eff;
    logic load_main_in, load_skid_in, load_main_skid;

    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign in_en_eff = in_wr_enable & ((DROP_R0 == 0) || (in_wr_address != '0));

    // State register; in_ready follows the next state so it is already correct
    // on the cycle the state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && !pop) begin
                        load_skid_in = 1'b1;
                        state_d      = S_TWO;
                    end else if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_d        = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_addr_q <= '0;
            main_data_q <= '0;
            main_en_q   <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            skid_en_q   <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_addr_q <= in_wr_address;
                main_data_q <= in_wr_data;
                main_en_q   <= in_en_eff;
            end else if (load_main_skid) begin
                main_addr_q <= skid_addr_q;
                main_data_q <= skid_data_q;
                main_en_q   <= skid_en_q;
            end
            if (load_skid_in) begin
                skid_addr_q <= in_wr_address;
                skid_data_q <= in_wr_data;
                skid_en_q   <= in_en_eff;
            end
        end
    end

    // Saturating count of cycles the head beat waited on downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        in_ready       = in_ready_q;
        out_valid      = (state_q != S_EMPTY);
        out_wr_enable  = out_valid & main_en_q;
        out_wr_address = main_addr_q;
        out_wr_data    = main_data_q;
        stall_cycles   = stall_q;
        if ((ZERO_ON_BUBBLE != 0) && !out_valid) begin
            out_wr_address = '0;
            out_wr_data    = '0;
        end
    end

endmodule

// File: tb/tb_exmem_skid.sv
// Bench for exmem_skid: queue-level reference model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_exmem_skid;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int W  = AW + DW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_wr_address = '0;
    logic [DW-1:0] in_wr_data = '0;
    logic          in_wr_enable = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_wr_address;
    logic [DW-1:0] out_wr_data;
    logic          out_wr_enable;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int passes = 0;

    exmem_skid #(.AW(AW), .DW(DW), .CW(CW), .DROP_R0(1), .ZERO_ON_BUBBLE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_address(in_wr_address), .in_wr_data(in_wr_data), .in_wr_enable(in_wr_enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wr_address(out_wr_address), .out_wr_data(out_wr_data), .out_wr_enable(out_wr_enable),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: beats held in FIFO order, {addr, data, stored enable}.
    logic [W-1:0] exp_q[$];
    logic         exp_in_ready = 1'b0;
    int           exp_stall = 0;
    bit           started = 0;

    always @(posedge clk) begin
        logic acc, pp;
        started = 1;
        acc = in_valid && exp_in_ready;
        pp  = (exp_q.size() > 0) && out_ready;
        if (rst) begin
            exp_q.delete();
            exp_in_ready = 1'b0;
            exp_stall = 0;
        end else begin
            if ((exp_q.size() > 0) && !out_ready && exp_stall < (1 << CW) - 1) exp_stall++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (pp) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({in_wr_address, in_wr_data,
                                          in_wr_enable && (in_wr_address != 0)});
            end
            exp_in_ready = (exp_q.size() < 2);
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] head;
        if (started) begin
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("m_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("m_in_ready", 64'(in_ready), 64'(exp_in_ready));
            check("m_out_addr", 64'(out_wr_address), 64'(head[W-1 -: AW]));
            check("m_out_data", 64'(out_wr_data), 64'(head[DW:1]));
            check("m_out_en", 64'(out_wr_enable), 64'(head[0]));
            check("m_stall", 64'(stall_cycles), 64'(exp_stall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        in_valid = v;
        in_wr_address = a;
        in_wr_data = d;
        in_wr_enable = e;
    endtask

    initial begin
        // 1: reset and a single transfer
        step(); step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        check("post_rst_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_addr", 64'(out_wr_address), 64'd5);
        check("t1_data", 64'(out_wr_data), 64'hDEADBEEF);
        check("t1_en", 64'(out_wr_enable), 64'd1);
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("t1_drained", 64'(out_valid), 64'd0);
        check("t1_stall", 64'(stall_cycles), 64'd0);

        // 2: back-pressure with A, B, C
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 32'h11, 1'b1); step();
        drive(1'b1, 5'd2, 32'h22, 1'b1); step();
        check("t2_ready_low", 64'(in_ready), 64'd0);
        check("t2_head_a", 64'(out_wr_address), 64'd1);
        check("t2_stall1", 64'(stall_cycles), 64'd1);
        drive(1'b1, 5'd3, 32'h33, 1'b1); step(); step();
        check("t2_hold_a", 64'(out_wr_data), 64'h11);
        check("t2_stall3", 64'(stall_cycles), 64'd3);
        out_ready = 1'b1; step();
        check("t2_out_b", 64'(out_wr_address), 64'd2);
        step();
        check("t2_out_c", 64'(out_wr_data), 64'h33);
        drive(1'b0, '0, '0, 1'b0); step();
        check("t2_empty", 64'(out_valid), 64'd0);

        // 3: full-rate streaming
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'(i), DW'(i), 1'b1);
            step();
            check("t3_valid", 64'(out_valid), 64'd1);
            check("t3_data", 64'(out_wr_data), 64'(i));
            check("t3_en", 64'(out_wr_enable), 64'(i != 0));
            check("t3_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, 1'b0); step();
        check("t3_end", 64'(out_valid), 64'd0);

        // 4: $zero suppression
        drive(1'b1, 5'd0, 32'h1234, 1'b1); step();
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_en", 64'(out_wr_enable), 64'd0);
        check("t4_data", 64'(out_wr_data), 64'h1234);
        drive(1'b0, '0, '0, 1'b0); step();

        // 5: flush with two beats held, then flush dropping a same-cycle accept
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 32'h77, 1'b1); step();
        drive(1'b1, 5'd8, 32'h88, 1'b1); step();
        flush = 1'b1; drive(1'b1, 5'd9, 32'h99, 1'b1); step();
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_en", 64'(out_wr_enable), 64'd0);
        check("t5_addr", 64'(out_wr_address), 64'd0);
        check("t5_data", 64'(out_wr_data), 64'd0);
        check("t5_ready", 64'(in_ready), 64'd1);
        check("t5_stall", 64'(stall_cycles), 64'd5);
        flush = 1'b0; drive(1'b0, '0, '0, 1'b0); out_ready = 1'b1; step();
        check("t5_no_ghost", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 5'd10, 32'hA0, 1'b1); step();
        flush = 1'b1; drive(1'b1, 5'd11, 32'hB0, 1'b1); step();
        flush = 1'b0; drive(1'b0, '0, '0, 1'b0); step();
        check("t5_drop_acc", 64'(out_valid), 64'd0);

        // 6: saturation, then reset mid-operation
        drive(1'b1, 5'd4, 32'h44, 1'b1); step();
        drive(1'b0, '0, '0, 1'b0);
        repeat (20) step();
        check("t6_sat", 64'(stall_cycles), 64'd15);
        check("t6_hold", 64'(out_wr_address), 64'd4);
        rst = 1'b1; step();
        check("t6_rst_stall", 64'(stall_cycles), 64'd0);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; out_ready = 1'b1; step();
        check("t6_ready", 64'(in_ready), 64'd1);
        check("t6_gone", 64'(out_valid), 64'd0);
        drive(1'b1, 5'd6, 32'h66, 1'b1); step();
        check("t6_again", 64'(out_wr_address), 64'd6);
        drive(1'b0, '0, '0, 1'b0); step();
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
